// File: rtl/c17_bist_ctrl.sv
// rtl/c17_bist_ctrl.sv - BIST sequencer for the c17 benchmark circuit
// Sweeps all 32 input vectors, checks against a golden c17 model, folds responses into a MISR.
module c17_bist_ctrl #(
   parameter int unsigned LAT  = 1,
   parameter logic [15:0] SEED = 16'hFFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic        N22,
   input  logic        N23,
   output logic        N1,
   output logic        N2,
   output logic        N3,
   output logic        N6,
   output logic        N7,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [5:0]  fail_cnt,
   output logic [4:0]  first_fail,
   output logic [15:0] signature
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_APPLY,
      S_CAPTURE,
      S_DONE
   } state_t;

   localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

   state_t      state_q, state_d;
   logic [4:0]  v_q, v_d;
   logic [3:0]  wait_q, wait_d;
   logic [15:0] sig_q, sig_d;
   logic [5:0]  fail_cnt_q, fail_cnt_d;
   logic [4:0]  first_fail_q, first_fail_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        pass_q, pass_d;

   logic n10, n11, n16, n19, exp22, exp23, mismatch;

   assign n10      = ~(v_q[0] & v_q[2]);
   assign n11      = ~(v_q[2] & v_q[3]);
   assign n16      = ~(v_q[1] & n11);
   assign n19      = ~(n11 & v_q[4]);
   assign exp22    = ~(n10 & n16);
   assign exp23    = ~(n16 & n19);
   assign mismatch = (N22 != exp22) || (N23 != exp23);

   always_comb begin
      state_d      = state_q;
      v_d          = v_q;
      wait_d       = wait_q;
      sig_d        = sig_q;
      fail_cnt_d   = fail_cnt_q;
      first_fail_d = first_fail_q;

      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_LOAD;
         end
         S_LOAD: begin
            sig_d        = SEED;
            fail_cnt_d   = 6'd0;
            first_fail_d = 5'd0;
            v_d          = 5'd0;
            wait_d       = 4'd0;
            state_d      = S_APPLY;
         end
         S_APPLY: begin
            wait_d = wait_q + 4'd1;
            if (wait_q == LAT_M1) state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            if (mismatch) begin
               fail_cnt_d = fail_cnt_q + 6'd1;
               if (fail_cnt_q == 6'd0) first_fail_d = v_q;
            end
            sig_d = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? 16'h1021 : 16'h0000)
                    ^ {14'b0, N23, N22};
            if (v_q == 5'd31) begin
               state_d = S_DONE;
            end else begin
               v_d     = v_q + 5'd1;
               wait_d  = 4'd0;
               state_d = S_APPLY;
            end
         end
         S_DONE: begin
            if (start) state_d = S_LOAD;
         end
         default: state_d = S_IDLE;
      endcase

      // Abort discards any in-flight capture but keeps the partial results.
      if (abort && (state_q == S_LOAD || state_q == S_APPLY || state_q == S_CAPTURE)) begin
         state_d      = S_IDLE;
         v_d          = 5'd0;
         wait_d       = 4'd0;
         sig_d        = sig_q;
         fail_cnt_d   = fail_cnt_q;
         first_fail_d = first_fail_q;
      end

      busy_d = (state_d == S_LOAD) || (state_d == S_APPLY) || (state_d == S_CAPTURE);
      // done follows one cycle after DONE is entered, once the final results have settled.
      done_d = (state_q == S_DONE) && (state_d == S_DONE);
      pass_d = done_d && (fail_cnt_q == 6'd0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         v_q          <= 5'd0;
         wait_q       <= 4'd0;
         sig_q        <= SEED;
         fail_cnt_q   <= 6'd0;
         first_fail_q <= 5'd0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         v_q          <= v_d;
         wait_q       <= wait_d;
         sig_q        <= sig_d;
         fail_cnt_q   <= fail_cnt_d;
         first_fail_q <= first_fail_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
      end
   end

   assign N1         = v_q[0];
   assign N2         = v_q[1];
   assign N3         = v_q[2];
   assign N6         = v_q[3];
   assign N7         = v_q[4];
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign fail_cnt   = fail_cnt_q;
   assign first_fail = first_fail_q;
   assign signature  = sig_q;

endmodule

// File: tb/tb_c17_bist_ctrl.sv
// tb/tb_c17_bist_ctrl.sv - self-checking bench for c17_bist_ctrl
// Two instances (LAT=1, LAT=3) fed by golden, stuck-at and pipelined c17 models.
module tb_c17_bist_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1;
   logic start_a = 1'b0, abort_a = 1'b0;
   logic start_b = 1'b0, abort_b = 1'b0;
   int   mode_a = 0;

   logic        n1_a, n2_a, n3_a, n6_a, n7_a, busy_a, done_a, pass_a;
   logic [5:0]  fc_a;
   logic [4:0]  ff_a;
   logic [15:0] sig_a;
   logic        n1_b, n2_b, n3_b, n6_b, n7_b, busy_b, done_b, pass_b;
   logic [5:0]  fc_b;
   logic [4:0]  ff_b;
   logic [15:0] sig_b;
   logic        n22_a, n23_a, n22_b, n23_b;

   logic [4:0] vec_a, vec_b;
   assign vec_a = {n7_a, n6_a, n3_a, n2_a, n1_a};
   assign vec_b = {n7_b, n6_b, n3_b, n2_b, n1_b};

   function automatic logic [1:0] c17(input logic [4:0] v);
      logic g10, g11, g16, g19;
      g10 = ~(v[0] & v[2]);
      g11 = ~(v[2] & v[3]);
      g16 = ~(v[1] & g11);
      g19 = ~(g11 & v[4]);
      return {~(g16 & g19), ~(g10 & g16)};
   endfunction

   logic [1:0] pipe_a [3];
   logic [1:0] pipe_b [3];
   always_ff @(posedge clk) begin
      pipe_a[0] <= c17(vec_a);
      pipe_a[1] <= pipe_a[0];
      pipe_a[2] <= pipe_a[1];
      pipe_b[0] <= c17(vec_b);
      pipe_b[1] <= pipe_b[0];
      pipe_b[2] <= pipe_b[1];
   end

   logic [1:0] gold_a;
   assign gold_a = c17(vec_a);
   always_comb begin
      n22_a = gold_a[0];
      n23_a = gold_a[1];
      if (mode_a == 1) n22_a = 1'b0;
      else if (mode_a == 2) begin
         n22_a = pipe_a[2][0];
         n23_a = pipe_a[2][1];
      end
   end
   assign n22_b = pipe_b[2][0];
   assign n23_b = pipe_b[2][1];

   c17_bist_ctrl #(.LAT(1), .SEED(16'hFFFF)) u_dut_a (
      .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
      .N22(n22_a), .N23(n23_a),
      .N1(n1_a), .N2(n2_a), .N3(n3_a), .N6(n6_a), .N7(n7_a),
      .busy(busy_a), .done(done_a), .pass(pass_a),
      .fail_cnt(fc_a), .first_fail(ff_a), .signature(sig_a)
   );

   c17_bist_ctrl #(.LAT(3), .SEED(16'hFFFF)) u_dut_b (
      .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
      .N22(n22_b), .N23(n23_b),
      .N1(n1_b), .N2(n2_b), .N3(n3_b), .N6(n6_b), .N7(n7_b),
      .busy(busy_b), .done(done_b), .pass(pass_b),
      .fail_cnt(fc_b), .first_fail(ff_b), .signature(sig_b)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // mode 0: golden responses; mode 1: N22 stuck at 0
   function automatic logic [15:0] sw_misr(input int mode, input int nvec);
      logic [15:0] s;
      logic [1:0]  r;
      s = 16'hFFFF;
      for (int v = 0; v < nvec; v++) begin
         r = c17(5'(v));
         if (mode == 1) r[0] = 1'b0;
         s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {14'b0, r};
      end
      return s;
   endfunction

   function automatic int n22_ones(input int nvec);
      int c;
      logic [1:0] r;
      c = 0;
      for (int v = 0; v < nvec; v++) begin
         r = c17(5'(v));
         if (r[0]) c++;
      end
      return c;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_to_done(input int sel, output int edges);
      if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
      tick();
      start_a = 1'b0;
      start_b = 1'b0;
      edges = -1;
      for (int n = 1; n <= 400; n++) begin
         tick();
         if ((sel == 0 && done_a) || (sel == 1 && done_b)) begin
            edges = n;
            break;
         end
      end
   endtask

   task automatic wait_vec_a(input logic [4:0] target);
      bit hit;
      hit = 1'b0;
      for (int n = 0; n < 200; n++) begin
         if (vec_a == target) begin
            hit = 1'b1;
            break;
         end
         tick();
      end
      check("wait_vec_timeout", 32'(hit), 32'd1);
   endtask

   typedef struct {
      int sel;
      int mode;
      int exp_edges;
      bit exp_pass;
      int exp_fc;
      int exp_ff;
      int sig_mode;
   } row_t;

   row_t rows [4];
   int   edges;
   logic [15:0] sig_first;
   bit   early;

   initial begin
      rows[0] = '{sel: 0, mode: 0, exp_edges: 66,  exp_pass: 1'b1, exp_fc: 0,  exp_ff: 0,  sig_mode: 0};
      rows[1] = '{sel: 0, mode: 1, exp_edges: 66,  exp_pass: 1'b0, exp_fc: 18, exp_ff: 2,  sig_mode: 1};
      rows[2] = '{sel: 1, mode: 0, exp_edges: 130, exp_pass: 1'b1, exp_fc: 0,  exp_ff: 0,  sig_mode: 0};
      rows[3] = '{sel: 0, mode: 2, exp_edges: 66,  exp_pass: 1'b0, exp_fc: -1, exp_ff: -1, sig_mode: -1};

      // reset and idle
      #1;
      repeat (3) tick();
      rst = 1'b0;
      repeat (10) tick();
      check("idle_vec",  32'(vec_a),  32'd0);
      check("idle_busy", 32'(busy_a), 32'd0);
      check("idle_done", 32'(done_a), 32'd0);
      check("idle_pass", 32'(pass_a), 32'd0);
      check("idle_sig",  32'(sig_a),  32'hFFFF);
      check("idle_fc",   32'(fc_a),   32'd0);
      check("idle_ff",   32'(ff_a),   32'd0);
      check("idle_sig_b", 32'(sig_b), 32'hFFFF);

      // clean run: vector order, hold time, done edge, start ignored while busy
      mode_a  = 0;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      early   = 1'b0;
      for (int e = 1; e <= 66; e++) begin
         if (e == 10) start_a = 1'b1;
         if (e == 11) start_a = 1'b0;
         tick();
         if (e <= 64) check($sformatf("vec_e%0d", e), 32'(vec_a), 32'((e - 1) / 2));
         if (e < 66 && done_a) early = 1'b1;
         if (e == 2) check("busy_run", 32'(busy_a), 32'd1);
      end
      check("done_early", 32'(early), 32'd0);
      check("done_e66",   32'(done_a), 32'd1);
      check("clean_pass", 32'(pass_a), 32'd1);
      check("clean_sig",  32'(sig_a),  32'(sw_misr(0, 32)));
      check("done_vec31", 32'(vec_a),  32'd31);

      // table-driven full runs
      for (int i = 0; i < 4; i++) begin
         mode_a = rows[i].mode;
         run_to_done(rows[i].sel, edges);
         check($sformatf("row%0d_edges", i), 32'(edges), 32'(rows[i].exp_edges));
         if (rows[i].sel == 0) begin
            check($sformatf("row%0d_pass", i), 32'(pass_a), 32'(rows[i].exp_pass));
            check($sformatf("row%0d_busy", i), 32'(busy_a), 32'd0);
            if (rows[i].exp_fc >= 0) check($sformatf("row%0d_fc", i), 32'(fc_a), 32'(rows[i].exp_fc));
            if (rows[i].exp_ff >= 0) check($sformatf("row%0d_ff", i), 32'(ff_a), 32'(rows[i].exp_ff));
            if (rows[i].sig_mode >= 0)
               check($sformatf("row%0d_sig", i), 32'(sig_a), 32'(sw_misr(rows[i].sig_mode, 32)));
         end else begin
            check($sformatf("row%0d_pass", i), 32'(pass_b), 32'(rows[i].exp_pass));
            check($sformatf("row%0d_busy", i), 32'(busy_b), 32'd0);
            if (rows[i].exp_fc >= 0) check($sformatf("row%0d_fc", i), 32'(fc_b), 32'(rows[i].exp_fc));
            if (rows[i].exp_ff >= 0) check($sformatf("row%0d_ff", i), 32'(ff_b), 32'(rows[i].exp_ff));
            if (rows[i].sig_mode >= 0)
               check($sformatf("row%0d_sig", i), 32'(sig_b), 32'(sw_misr(rows[i].sig_mode, 32)));
         end
      end
      check("stuck_count_model", 32'd18, 32'(n22_ones(32)));

      // abort mid-run at vector 10 with N22 stuck, partial results kept
      mode_a  = 1;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      wait_vec_a(5'd10);
      abort_a = 1'b1;
      tick();
      abort_a = 1'b0;
      check("abort_busy", 32'(busy_a), 32'd0);
      check("abort_done", 32'(done_a), 32'd0);
      check("abort_vec",  32'(vec_a),  32'd0);
      check("abort_fc",   32'(fc_a),   32'(n22_ones(10)));
      check("abort_sig",  32'(sig_a),  32'(sw_misr(1, 10)));
      abort_a = 1'b1;
      repeat (3) tick();
      abort_a = 1'b0;
      check("abort_idle_busy", 32'(busy_a), 32'd0);
      mode_a = 0;
      run_to_done(0, edges);
      check("post_abort_edges", 32'(edges), 32'd66);
      check("post_abort_pass",  32'(pass_a), 32'd1);
      check("post_abort_fc",    32'(fc_a),   32'd0);
      check("post_abort_sig",   32'(sig_a),  32'(sw_misr(0, 32)));

      // reset mid-run at vector 20
      mode_a  = 1;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      wait_vec_a(5'd20);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mrst_vec",  32'(vec_a),  32'd0);
      check("mrst_busy", 32'(busy_a), 32'd0);
      check("mrst_done", 32'(done_a), 32'd0);
      check("mrst_pass", 32'(pass_a), 32'd0);
      check("mrst_fc",   32'(fc_a),   32'd0);
      check("mrst_ff",   32'(ff_a),   32'd0);
      check("mrst_sig",  32'(sig_a),  32'hFFFF);
      repeat (4) tick();
      check("mrst_stay_idle", 32'(busy_a), 32'd0);

      // restart from DONE gives an identical signature
      mode_a = 0;
      run_to_done(0, edges);
      check("rs1_edges", 32'(edges), 32'd66);
      sig_first = sig_a;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      check("rs_busy_load", 32'(busy_a), 32'd1);
      tick();
      check("rs_done_clear", 32'(done_a), 32'd0);
      edges = -1;
      for (int n = 2; n <= 200; n++) begin
         tick();
         if (done_a) begin
            edges = n;
            break;
         end
      end
      check("rs2_edges", 32'(edges), 32'd66);
      check("rs2_sig_same", 32'(sig_a), 32'(sig_first));
      check("rs2_sig_model", 32'(sig_a), 32'(sw_misr(0, 32)));
      check("rs2_pass", 32'(pass_a), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
